// File: rtl/arcade_input_ctrl.sv
// Purpose: arcade input front end. Decodes PS/2 keys and HPS joysticks into per-player
//          control vectors, stretches coin pulses, and captures the game-select byte and DIP bank.
// Latency: joystick->ctl 1 cycle, PS/2 event->ctl/test 2 cycles, ioctl write->mod/dip 1 cycle,
//          download fall->dip_valid 1 cycle.
// Backpressure: none. Every input is sampled every cycle and nothing is ever stalled.
//
// Ports:
//   clk_sys                  system clock (only clock)
//   reset                    synchronous, active-high; clears key state, coin counters, ctl, test
//   ps2_key[10:0]            [10] toggles per event, [9] pressed, [8:0] scan code (bit 8 = extended)
//   joystick_0/1[15:0]       HPS joystick words; bits 0..7 = right,left,down,up,fire,start,fire2,coin
//   joy_merge                1: both players see joystick_0 | joystick_1
//   ioctl_*                  HPS download stream (mod / DIP capture)
//   ctl[8*PLAYERS-1:0]       per player {coin,start,fire2,fire,up,down,left,right}, active-high
//   test                     service/test key (T)
//   mod[7:0]                 game-select byte
//   dip[8*NUM_DIP-1:0]       DIP bank, byte n at [8n+7:8n]
//   dip_valid                DIP bank has been downloaded at least once
//
// Optional feature: define ARCADE_COIN_STRETCH_EN to hold each coin output high for at
// least COIN_PULSE cycles after a rising edge of the raw coin signal. Without it the coin
// bit simply follows the raw key/joystick coin.

module arcade_input_ctrl #(
    parameter int PLAYERS    = 2,
    parameter int NUM_DIP    = 8,
    parameter int COIN_PULSE = 120000,
    parameter int MOD_INDEX  = 1,
    parameter int DIP_INDEX  = 254
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    input  logic [15:0]            joystick_0,
    input  logic [15:0]            joystick_1,
    input  logic                   joy_merge,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic [8*PLAYERS-1:0]   ctl,
    output logic                   test,
    output logic [7:0]             mod,
    output logic [8*NUM_DIP-1:0]   dip,
    output logic                   dip_valid
);

    // ------------------------------------------------------------------
    // Physical key register indices. Each physical key keeps its own
    // state so that two keys sharing a function (Space/LCtrl, 1/F1, ...)
    // do not release each other.
    // ------------------------------------------------------------------
    localparam int K_P0_UP  = 0;
    localparam int K_P0_DN  = 1;
    localparam int K_P0_LF  = 2;
    localparam int K_P0_RT  = 3;
    localparam int K_SPACE  = 4;
    localparam int K_LCTRL  = 5;
    localparam int K_LALT   = 6;
    localparam int K_1      = 7;
    localparam int K_F1     = 8;
    localparam int K_5      = 9;
    localparam int K_R      = 10;
    localparam int K_F      = 11;
    localparam int K_D      = 12;
    localparam int K_G      = 13;
    localparam int K_A      = 14;
    localparam int K_S      = 15;
    localparam int K_2      = 16;
    localparam int K_F2     = 17;
    localparam int K_6      = 18;
    localparam int K_T      = 19;
    localparam int NK       = 20;

    logic [NK-1:0] keys;
    logic [NK-1:0] key_sel;
    logic          tog_q;
    logic          ps2_ev;

    assign ps2_ev = ps2_key[10] ^ tog_q;

    // One-hot decode of the scan code; unmapped codes select nothing.
    always_comb begin
        key_sel = '0;
        case (ps2_key[8:0])
            9'h175: key_sel[K_P0_UP] = 1'b1;
            9'h172: key_sel[K_P0_DN] = 1'b1;
            9'h16B: key_sel[K_P0_LF] = 1'b1;
            9'h174: key_sel[K_P0_RT] = 1'b1;
            9'h029: key_sel[K_SPACE] = 1'b1;
            9'h014: key_sel[K_LCTRL] = 1'b1;
            9'h011: key_sel[K_LALT]  = 1'b1;
            9'h016: key_sel[K_1]     = 1'b1;
            9'h005: key_sel[K_F1]    = 1'b1;
            9'h02E: key_sel[K_5]     = 1'b1;
            9'h02D: key_sel[K_R]     = 1'b1;
            9'h02B: key_sel[K_F]     = 1'b1;
            9'h023: key_sel[K_D]     = 1'b1;
            9'h034: key_sel[K_G]     = 1'b1;
            9'h01C: key_sel[K_A]     = 1'b1;
            9'h01B: key_sel[K_S]     = 1'b1;
            9'h01E: key_sel[K_2]     = 1'b1;
            9'h006: key_sel[K_F2]    = 1'b1;
            9'h036: key_sel[K_6]     = 1'b1;
            9'h02C: key_sel[K_T]     = 1'b1;
            default: key_sel = '0;
        endcase
    end

    // The toggle copy follows ps2_key[10] even during reset, so an event that
    // coincides with reset is swallowed instead of firing once reset drops.
    always_ff @(posedge clk_sys) begin
        tog_q <= ps2_key[10];
        if (reset) begin
            keys <= '0;
        end else if (ps2_ev) begin
            for (int i = 0; i < NK; i++) begin
                if (key_sel[i]) begin
                    keys[i] <= ps2_key[9];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-player raw control vectors: keys ORed with the selected joystick.
    // Joystick bit order differs from ctl in the start/fire2 positions.
    // ------------------------------------------------------------------
    function automatic logic [7:0] joy_map(input logic [7:0] j);
        return {j[7], j[5], j[6], j[4], j[3], j[2], j[1], j[0]};
    endfunction

    logic [7:0] p_key [2];
    logic [7:0] raw   [PLAYERS];
    logic [7:0] joy_or;
    logic       unused_joy_hi;

    assign unused_joy_hi = ^{joystick_0[15:8], joystick_1[15:8]};
    assign joy_or        = joystick_0[7:0] | joystick_1[7:0];

    always_comb begin
        p_key[0] = {keys[K_5], keys[K_1] | keys[K_F1], keys[K_LALT],
                    keys[K_SPACE] | keys[K_LCTRL],
                    keys[K_P0_UP], keys[K_P0_DN], keys[K_P0_LF], keys[K_P0_RT]};
        p_key[1] = {keys[K_6], keys[K_2] | keys[K_F2], keys[K_S], keys[K_A],
                    keys[K_R], keys[K_F], keys[K_D], keys[K_G]};
    end

    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            if (joy_merge) begin
                raw[p] = p_key[p] | joy_map(joy_or);
            end else if (p == 0) begin
                raw[p] = p_key[p] | joy_map(joystick_0[7:0]);
            end else begin
                raw[p] = p_key[p] | joy_map(joystick_1[7:0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Coin conditioning
    // ------------------------------------------------------------------
    logic [PLAYERS-1:0] coin_out;

`ifdef ARCADE_COIN_STRETCH_EN
    localparam int CW = $clog2(COIN_PULSE + 1);

    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          raw_q;

        // Only an edge seen while idle arms the counter; later edges inside the
        // window do not extend it.
        always_comb begin
            cnt_d = cnt_q;
            if (raw[p][7] && !raw_q && (cnt_q == '0)) begin
                cnt_d = CW'(COIN_PULSE);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                cnt_q <= '0;
                raw_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                raw_q <= raw[p][7];
            end
        end

        // Uses the next counter value so the registered coin is high for exactly
        // COIN_PULSE cycles from the edge.
        assign coin_out[p] = raw[p][7] | (cnt_d != '0);
    end
`else
    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        assign coin_out[p] = raw[p][7];
    end
`endif

    // ------------------------------------------------------------------
    // Registered control outputs
    // ------------------------------------------------------------------
    logic [8*PLAYERS-1:0] ctl_q;
    logic                 test_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ctl_q  <= '0;
            test_q <= 1'b0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                ctl_q[8*p +: 8] <= {coin_out[p], raw[p][6:0]};
            end
            test_q <= keys[K_T];
        end
    end

    assign ctl  = ctl_q;
    assign test = test_q;

    // ------------------------------------------------------------------
    // Download capture. Deliberately not reset: the core sits in reset for the
    // whole download, and the captured values must survive it.
    // ------------------------------------------------------------------
    logic [7:0]           mod_q       = 8'h00;
    logic [8*NUM_DIP-1:0] dip_q       = '1;
    logic                 dip_valid_q = 1'b0;
    logic                 dl_q        = 1'b0;
    logic [7:0]           idx_q       = 8'h00;

    always_ff @(posedge clk_sys) begin
        dl_q <= ioctl_download;
        if (ioctl_download) begin
            idx_q <= ioctl_index;
        end

        if (dl_q && !ioctl_download && (idx_q == 8'(DIP_INDEX))) begin
            dip_valid_q <= 1'b1;
        end

        if (ioctl_wr && (ioctl_index == 8'(MOD_INDEX))) begin
            mod_q <= ioctl_dout;
        end

        // Full-width address compare: out-of-range addresses never alias.
        for (int n = 0; n < NUM_DIP; n++) begin
            if (ioctl_wr && (ioctl_index == 8'(DIP_INDEX)) && (ioctl_addr == 25'(n))) begin
                dip_q[8*n +: 8] <= ioctl_dout;
            end
        end
    end

    assign mod       = mod_q;
    assign dip       = dip_q;
    assign dip_valid = dip_valid_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Purpose: self-checking bench for arcade_input_ctrl (PLAYERS=2, NUM_DIP=8, COIN_PULSE=100).
// Latency: expectations follow the documented 1/2-cycle output latencies.
// Backpressure: none; expectations are queued as stimulus is driven and popped on observation.

module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        joy_merge;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] ctl;
    logic        test;
    logic [7:0]  mod;
    logic [63:0] dip;
    logic        dip_valid;

    arcade_input_ctrl #(
        .PLAYERS    (2),
        .NUM_DIP    (8),
        .COIN_PULSE (100),
        .MOD_INDEX  (1),
        .DIP_INDEX  (254)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ps2_key        (ps2_key),
        .joystick_0     (joystick_0),
        .joystick_1     (joystick_1),
        .joy_merge      (joy_merge),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ctl            (ctl),
        .test           (test),
        .mod            (mod),
        .dip            (dip),
        .dip_valid      (dip_valid)
    );

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    logic tog     = 1'b0;

`ifdef ARCADE_COIN_STRETCH_EN
    localparam int COIN_ONE = 100;
    localparam int COIN_TWO = 100;
`else
    localparam int COIN_ONE = 3;
    localparam int COIN_TWO = 6;
`endif

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic push(input string name, input logic [63:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic ps2_event(input logic [8:0] code, input logic pressed);
        tog     = ~tog;
        ps2_key = {tog, pressed, code};
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0; joy_merge = 1'b0;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
        tick(2);
        push("reset_ctl", 64'h0);       push("reset_test", 64'h0);
        push("powerup_mod", 64'h0);     push("powerup_dip", {64{1'b1}});
        push("powerup_dip_valid", 64'h0);
        e = sb.pop_front(); vectors++;
        if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
        e = sb.pop_front(); vectors++;
        if (test !== e.val[0]) begin errors++; $display("FAIL %s: got %b want %b", e.name, test, e.val[0]); end
        e = sb.pop_front(); vectors++;
        if (mod !== e.val[7:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, mod, e.val[7:0]); end
        e = sb.pop_front(); vectors++;
        if (dip !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, dip, e.val); end
        e = sb.pop_front(); vectors++;
        if (dip_valid !== e.val[0]) begin errors++; $display("FAIL %s: got %b want %b", e.name, dip_valid, e.val[0]); end
        reset = 1'b0;
        tick();
    endtask

    // Each entry: scan code, pressed, cycles to wait, expected ctl, expected test.
    typedef struct {
        string      name;
        logic [8:0] code;
        logic       pressed;
        logic       same_tog;
        int         wait_cyc;
        logic [15:0] exp_ctl;
        logic       exp_test;
    } ps2_vec_t;

    task automatic test_ps2();
        exp_t     e;
        ps2_vec_t v [14];
        v[0]  = '{"fire_latency1",   9'h029, 1'b1, 1'b0, 1, 16'h0000, 1'b0};
        v[1]  = '{"fire_press",      9'h029, 1'b1, 1'b1, 1, 16'h0010, 1'b0};
        v[2]  = '{"same_toggle",     9'h029, 1'b0, 1'b1, 3, 16'h0010, 1'b0};
        v[3]  = '{"fire_release",    9'h029, 1'b0, 1'b0, 2, 16'h0000, 1'b0};
        v[4]  = '{"p0_up_ext",       9'h175, 1'b1, 1'b0, 2, 16'h0008, 1'b0};
        v[5]  = '{"unmapped_075",    9'h075, 1'b1, 1'b0, 2, 16'h0008, 1'b0};
        v[6]  = '{"repeat_press",    9'h175, 1'b1, 1'b0, 2, 16'h0008, 1'b0};
        v[7]  = '{"p1_fire_a",       9'h01C, 1'b1, 1'b0, 2, 16'h1008, 1'b0};
        v[8]  = '{"p1_start_f2",     9'h006, 1'b1, 1'b0, 2, 16'h5008, 1'b0};
        v[9]  = '{"test_key",        9'h02C, 1'b1, 1'b0, 2, 16'h5008, 1'b1};
        v[10] = '{"rel_up",          9'h175, 1'b0, 1'b0, 2, 16'h5000, 1'b1};
        v[11] = '{"rel_p1_fire",     9'h01C, 1'b0, 1'b0, 2, 16'h4000, 1'b1};
        v[12] = '{"rel_p1_start",    9'h006, 1'b0, 1'b0, 2, 16'h0000, 1'b1};
        v[13] = '{"rel_test",        9'h02C, 1'b0, 1'b0, 2, 16'h0000, 1'b0};
        for (int i = 0; i < 14; i++) begin
            if (v[i].same_tog) ps2_key = {tog, v[i].pressed, v[i].code};
            else               ps2_event(v[i].code, v[i].pressed);
            push({v[i].name, "_ctl"}, {48'h0, v[i].exp_ctl});
            push({v[i].name, "_test"}, {63'h0, v[i].exp_test});
            tick(v[i].wait_cyc);
            e = sb.pop_front(); vectors++;
            if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
            e = sb.pop_front(); vectors++;
            if (test !== e.val[0]) begin errors++; $display("FAIL %s: got %b want %b", e.name, test, e.val[0]); end
        end
        // Two physical keys on one function: releasing one keeps fire held.
        ps2_event(9'h029, 1'b1); tick();
        ps2_event(9'h014, 1'b1); tick();
        ps2_event(9'h029, 1'b0); tick(2);
        push("fire_two_keys", 64'h0010);
        e = sb.pop_front(); vectors++;
        if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
        ps2_event(9'h014, 1'b0); tick(2);
        push("fire_two_keys_rel", 64'h0000);
        e = sb.pop_front(); vectors++;
        if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
    endtask

    task automatic test_joystick();
        exp_t e;
        logic [15:0] j0 [4];
        logic [15:0] j1 [4];
        logic        mg [4];
        logic [15:0] ex [4];
        string       nm [4];
        j0[0] = 16'h0000; j1[0] = 16'h0010; mg[0] = 1'b0; ex[0] = 16'h1000; nm[0] = "joy1_fire_sep";
        j0[1] = 16'h0000; j1[1] = 16'h0010; mg[1] = 1'b1; ex[1] = 16'h1010; nm[1] = "joy1_fire_merge";
        j0[2] = 16'hFF20; j1[2] = 16'h0000; mg[2] = 1'b0; ex[2] = 16'h0040; nm[2] = "joy0_start_remap";
        j0[3] = 16'h0041; j1[3] = 16'h0006; mg[3] = 1'b1; ex[3] = 16'h2727; nm[3] = "merge_mixed";
        for (int i = 0; i < 4; i++) begin
            joystick_0 = j0[i]; joystick_1 = j1[i]; joy_merge = mg[i];
            push(nm[i], {48'h0, ex[i]});
            tick();
            e = sb.pop_front(); vectors++;
            if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
        end
        joystick_0 = '0; joystick_1 = '0; joy_merge = 1'b0;
        tick(3);
    endtask

    task automatic test_mod();
        exp_t e;
        logic [7:0]  idx [3];
        logic [7:0]  dat [3];
        logic [24:0] adr [3];
        idx[0] = 8'd1; dat[0] = 8'h03; adr[0] = 25'd5;
        idx[1] = 8'd1; dat[1] = 8'h0F; adr[1] = 25'h1FFFFFF;
        idx[2] = 8'd0; dat[2] = 8'hAA; adr[2] = 25'd0;
        push("mod_first", 64'h03); push("mod_last_wins", 64'h0F); push("mod_other_index", 64'h0F);
        for (int i = 0; i < 3; i++) begin
            ioctl_index = idx[i]; ioctl_dout = dat[i]; ioctl_addr = adr[i]; ioctl_wr = 1'b1;
            tick();
            ioctl_wr = 1'b0;
            e = sb.pop_front(); vectors++;
            if (mod !== e.val[7:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, mod, e.val[7:0]); end
        end
        ioctl_index = '0;
    endtask

    task automatic test_dip();
        exp_t e;
        ioctl_download = 1'b1; ioctl_index = 8'd254;
        for (int i = 0; i < 9; i++) begin
            ioctl_addr = 25'(i); ioctl_dout = 8'(8'h11 + i); ioctl_wr = 1'b1;
            tick();
        end
        ioctl_wr = 1'b0;
        tick();
        ioctl_download = 1'b0;
        push("dip_valid_before_edge", 64'h0);
        e = sb.pop_front(); vectors++;
        if (dip_valid !== e.val[0]) begin errors++; $display("FAIL %s: got %b want %b", e.name, dip_valid, e.val[0]); end
        tick();
        push("dip_valid_after_fall", 64'h1);
        push("dip_bytes", 64'h1817161514131211);
        e = sb.pop_front(); vectors++;
        if (dip_valid !== e.val[0]) begin errors++; $display("FAIL %s: got %b want %b", e.name, dip_valid, e.val[0]); end
        e = sb.pop_front(); vectors++;
        if (dip !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, dip, e.val); end
        ioctl_index = '0;
        reset = 1'b1; tick(2); reset = 1'b0; tick();
        push("dip_kept_reset", 64'h1817161514131211);
        push("dip_valid_kept_reset", 64'h1);
        push("mod_kept_reset", 64'h0F);
        e = sb.pop_front(); vectors++;
        if (dip !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, dip, e.val); end
        e = sb.pop_front(); vectors++;
        if (dip_valid !== e.val[0]) begin errors++; $display("FAIL %s: got %b want %b", e.name, dip_valid, e.val[0]); end
        e = sb.pop_front(); vectors++;
        if (mod !== e.val[7:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, mod, e.val[7:0]); end
    endtask

    task automatic test_coin_stretch();
        exp_t e;
        int   cnt;
        for (int run = 0; run < 2; run++) begin
            push(run == 0 ? "coin_single_pulse" : "coin_second_pulse", 64'(run == 0 ? COIN_ONE : COIN_TWO));
            cnt = 0;
            joystick_0 = 16'h0080;
            for (int i = 1; i <= 200; i++) begin
                @(posedge clk_sys); #1;
                if (ctl[7]) cnt++;
                if (i == 3) joystick_0 = 16'h0000;
                if (run == 1 && i == 50) joystick_0 = 16'h0080;
                if (run == 1 && i == 53) joystick_0 = 16'h0000;
            end
            e = sb.pop_front(); vectors++;
            if (64'(cnt) !== e.val) begin errors++; $display("FAIL %s: high %0d cycles want %0d", e.name, cnt, e.val); end
        end
    endtask

    task automatic test_reset_mid_press();
        exp_t e;
        push("coin_key_press", 64'h0080);
        push("coin_cleared_by_reset", 64'h0000);
        push("coin_held_no_event", 64'h0000);
        push("toggle_in_reset_dropped", 64'h0000);
        push("coin_repress", 64'h0080);
        push("coin_release", 64'h0000);
        ps2_event(9'h02E, 1'b1); tick(2);
        e = sb.pop_front(); vectors++;
        if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
        reset = 1'b1; tick(); reset = 1'b0;
        e = sb.pop_front(); vectors++;
        if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
        tick(5);
        e = sb.pop_front(); vectors++;
        if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
        reset = 1'b1; ps2_event(9'h029, 1'b1); tick(); reset = 1'b0;
        tick(3);
        e = sb.pop_front(); vectors++;
        if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
        ps2_event(9'h02E, 1'b1); tick(2);
        e = sb.pop_front(); vectors++;
        if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
        ps2_event(9'h02E, 1'b0); tick(150);
        e = sb.pop_front(); vectors++;
        if (ctl !== e.val[15:0]) begin errors++; $display("FAIL %s: got %h want %h", e.name, ctl, e.val[15:0]); end
    endtask

    initial begin
        test_reset();
        test_ps2();
        test_joystick();
        test_mod();
        test_dip();
        test_coin_stretch();
        test_reset_mid_press();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
